fp_mul_pack: RTL

Final stage of the single-precision multiplier pipeline. It consumes the 11-bit auxiliary flag word together with the sign, biased exponent and truncated mantissa of the same operation. It applies the round increment, resolves the special cases (NaN, infinity, zero, flush-to-zero, overflow, underflow), and emits a packed IEEE-754 binary32 result. Two registered stages with valid/ready flow control let the multiplier stall on downstream back-pressure.

---
 rtl/fpmul_pkg.sv | 35 +++
 rtl/fp_round_inc.sv | 18 +
 rtl/fp_mul_pack.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fpmul_pkg.sv
// Shared constants and types for the binary32 multiplier pack stage.
// Flag word bit positions, exception bit positions and special encodings.
package fpmul_pkg;

    localparam int FLG_AP_ZF   = 10;
    localparam int FLG_AP_DNF  = 9;
    localparam int FLG_AP_INFF = 8;
    localparam int FLG_AP_NANF = 7;
    localparam int FLG_ROUND   = 6;
    localparam int FLG_UNF     = 5;
    localparam int FLG_OVF     = 4;
    localparam int FLG_AB_NAN  = 3;
    localparam int FLG_AB_INF  = 2;
    localparam int FLG_AB_ZERO = 1;
    localparam int FLG_AB_DNF  = 0;

    localparam int EXC_INVALID   = 3;
    localparam int EXC_OVERFLOW  = 2;
    localparam int EXC_UNDERFLOW = 1;
    localparam int EXC_INEXACT   = 0;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    typedef struct packed {
        logic ab_nan;
        logic ab_inf;
        logic ab_zero;
        logic ab_dnf;
        logic ovf;
        logic unf;
        logic rnd;
    } s1_flags_t;

endpackage

// File: rtl/fp_round_inc.sv
// Round increment: adds the round bit to the 23-bit fraction, carrying into a 9-bit exponent.
// Latency: combinational. Backpressure: none (pure logic).
// A fraction carry leaves the low 23 sum bits at zero, which is the wrapped mantissa.
module fp_round_inc (
    input  logic [7:0]  i_exp,
    input  logic [22:0] i_mant,
    input  logic        i_inc,
    output logic [8:0]  o_exp,
    output logic [22:0] o_mant
);

    logic [23:0] w_sum;

    assign w_sum  = {1'b0, i_mant} + {23'd0, i_inc};
    assign o_mant = w_sum[22:0];
    assign o_exp  = w_sum[23] ? ({1'b0, i_exp} + 9'd1) : {1'b0, i_exp};

endmodule

// File: rtl/fp_mul_pack.sv
// Final multiplier stage: rounds, resolves special cases, packs binary32; sticky status with FPMUL_STATUS_EN.
// Latency: 2 cycles, 1 beat/cycle throughput.
// Backpressure: two-entry skid via per-stage hold; in_ready is combinational from out_ready.
module fp_mul_pack
    import fpmul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [22:0] in_mant,
    input  logic [10:0] in_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_exc
`ifdef FPMUL_STATUS_EN
    ,
    input  logic        status_clr,
    output logic [3:0]  status
`endif
);

    logic        r_s1_vld;
    logic        r_s1_sign;
    logic [8:0]  r_s1_exp;
    logic [22:0] r_s1_mant;
    s1_flags_t   r_s1_flg;

    logic        r_s2_vld;
    logic [31:0] r_s2_res;
    logic [3:0]  r_s2_exc;

    logic        w_s1_adv;
    logic        w_s2_adv;
    logic [8:0]  w_exp_r;
    logic [22:0] w_mant_r;
    s1_flags_t   w_flg;
    logic [31:0] w_res;
    logic [3:0]  w_exc;
    logic        w_unused_ap;

    // The AP_* operand-class flags are carried by the flag word but not needed for packing.
    assign w_unused_ap = ^in_flags[FLG_AP_ZF:FLG_AP_NANF];

    assign w_s2_adv = ~r_s2_vld | out_ready;
    assign w_s1_adv = ~r_s1_vld | w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_flg = '{ab_nan:  in_flags[FLG_AB_NAN],
                     ab_inf:  in_flags[FLG_AB_INF],
                     ab_zero: in_flags[FLG_AB_ZERO],
                     ab_dnf:  in_flags[FLG_AB_DNF],
                     ovf:     in_flags[FLG_OVF],
                     unf:     in_flags[FLG_UNF],
                     rnd:     in_flags[FLG_ROUND]};

    fp_round_inc u_round (
        .i_exp  (in_exp),
        .i_mant (in_mant),
        .i_inc  (in_flags[FLG_ROUND]),
        .o_exp  (w_exp_r),
        .o_mant (w_mant_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_mant <= '0;
            r_s1_flg  <= '0;
        end else if (w_s1_adv) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_sign;
                r_s1_exp  <= w_exp_r;
                r_s1_mant <= w_mant_r;
                r_s1_flg  <= w_flg;
            end
        end
    end

    always_comb begin
        w_res              = {r_s1_sign, r_s1_exp[7:0], r_s1_mant};
        w_exc              = '0;
        w_exc[EXC_INEXACT] = r_s1_flg.rnd;
        if (r_s1_flg.ab_nan) begin
            w_res              = QNAN;
            w_exc              = '0;
            w_exc[EXC_INVALID] = 1'b1;
        end else if (r_s1_flg.ab_inf) begin
            w_res = {r_s1_sign, EXP_MAX, 23'd0};
            w_exc = '0;
        end else if (r_s1_flg.ab_zero) begin
            w_res = {r_s1_sign, 8'd0, 23'd0};
            w_exc = '0;
        end else if (r_s1_flg.ab_dnf || (!r_s1_flg.ovf && r_s1_exp < {1'b0, EXP_MAX} && r_s1_flg.unf)) begin
            // Denormal operands flush to zero; plain underflow lands on the same encoding.
            w_res                = {r_s1_sign, 8'd0, 23'd0};
            w_exc                = '0;
            w_exc[EXC_UNDERFLOW] = 1'b1;
            w_exc[EXC_INEXACT]   = 1'b1;
        end else if (r_s1_flg.ovf || r_s1_exp >= {1'b0, EXP_MAX}) begin
            w_res               = {r_s1_sign, EXP_MAX, 23'd0};
            w_exc               = '0;
            w_exc[EXC_OVERFLOW] = 1'b1;
            w_exc[EXC_INEXACT]  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_s2_res <= '0;
            r_s2_exc <= '0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_res <= w_res;
                r_s2_exc <= w_exc;
            end
        end
    end

    assign out_valid  = r_s2_vld;
    assign out_result = r_s2_res;
    assign out_exc    = r_s2_exc;

`ifdef FPMUL_STATUS_EN
    logic [3:0] r_status;
    logic       w_hs;

    assign w_hs = r_s2_vld & out_ready;

    // A clear coinciding with a handshake keeps that beat's bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
        end else if (status_clr) begin
            r_status <= w_hs ? r_s2_exc : 4'd0;
        end else if (w_hs) begin
            r_status <= r_status | r_s2_exc;
        end
    end

    assign status = r_status;
`endif

endmodule
